// File: rtl/register_file_multiport_pkg.sv
// register_file_multiport_pkg: shared state encoding and default widths for the register file
package register_file_multiport_pkg;
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_READ_PORTS = 2;
endpackage

// File: rtl/register_file_multiport_if.sv
// register_file_multiport_if: read, write, writeback-release and issue-reserve signals of the register file
interface register_file_multiport_if
    import register_file_multiport_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int READ_PORTS = DEFAULT_READ_PORTS
);
    logic ready;
    logic [READ_PORTS-1:0] read_enable;
    logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_address;
    logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [READ_PORTS-1:0] read_busy;
    logic write_enable_0, write_enable_1;
    logic [ADDRESS_WIDTH-1:0] write_address_0, write_address_1;
    logic [DATA_WIDTH-1:0] write_data_0, write_data_1;
    logic write_release_0, write_release_1;
    logic reserve_enable;
    logic [ADDRESS_WIDTH-1:0] reserve_address;
    modport master (
        input ready, read_data, read_busy,
        output read_enable, read_address, write_enable_0, write_enable_1,
        output write_address_0, write_address_1, write_data_0, write_data_1,
        output write_release_0, write_release_1, reserve_enable, reserve_address
    );
    modport slave (
        output ready, read_data, read_busy,
        input read_enable, read_address, write_enable_0, write_enable_1,
        input write_address_0, write_address_1, write_data_0, write_data_1,
        input write_release_0, write_release_1, reserve_enable, reserve_address
    );
endinterface

// File: rtl/register_file_multiport_read_port.sv
// register_file_multiport_read_port: one read port's write-bypass priority mux and busy qualification
module register_file_multiport_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter bit HARDWIRED_ZERO = 1'b1
) (
    input  logic                     ready_i,
    input  logic                     enable_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0]    storage_word_i,
    input  logic                     busy_i,
    input  logic                     write_enable_0_i,
    input  logic                     write_enable_1_i,
    input  logic [ADDRESS_WIDTH-1:0] write_address_0_i,
    input  logic [ADDRESS_WIDTH-1:0] write_address_1_i,
    input  logic [DATA_WIDTH-1:0]    write_data_0_i,
    input  logic [DATA_WIDTH-1:0]    write_data_1_i,
    input  logic                     write_release_0_i,
    input  logic                     write_release_1_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     busy_o
);
    logic live, hit_0, hit_1, released;
    always_comb begin
        live = ready_i && enable_i && !(HARDWIRED_ZERO && address_i == '0);
        hit_0 = write_enable_0_i && write_address_0_i == address_i;
        hit_1 = write_enable_1_i && write_address_1_i == address_i;
        released = (hit_0 && write_release_0_i) || (hit_1 && write_release_1_i);
        // port 1 outranks port 0, matching the storage write ordering
        data_o = !live ? '0 : hit_1 ? write_data_1_i : hit_0 ? write_data_0_i : storage_word_i;
        busy_o = live && busy_i && !released;
    end
endmodule

// File: rtl/register_file_multiport.sv
// register_file_multiport: multi-read, dual-write register file with bypass, busy scoreboard
// and a post-reset sequencer that zeroes storage one entry per cycle
module register_file_multiport
    import register_file_multiport_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int READ_PORTS = DEFAULT_READ_PORTS,
    parameter bit HARDWIRED_ZERO = 1'b1
) (
    input logic clock,
    input logic reset,
    register_file_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] FIRST_INDEX = ADDRESS_WIDTH'(HARDWIRED_ZERO);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(DEPTH - 1);

    state_e state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clear_index_q, clear_index_d;
    logic [DATA_WIDTH-1:0] storage_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic ready, write_0, write_1;
    logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [READ_PORTS-1:0] read_busy;

    assign ready = state_q == READY;
    assign write_0 = ready && bus.write_enable_0 && !(HARDWIRED_ZERO && bus.write_address_0 == '0);
    assign write_1 = ready && bus.write_enable_1 && !(HARDWIRED_ZERO && bus.write_address_1 == '0);
    assign bus.ready = ready;
    assign bus.read_data = read_data;
    assign bus.read_busy = read_busy;

    always_comb begin
        state_d = (state_q == CLEAR && clear_index_q == LAST_INDEX) ? READY : state_q;
        clear_index_d = (state_q == CLEAR && clear_index_q != LAST_INDEX) ? clear_index_q + 1'b1 : clear_index_q;
    end

    always_comb begin
        busy_d = busy_q;
        if (ready && bus.write_enable_0 && bus.write_release_0) busy_d[bus.write_address_0] = 1'b0;
        if (ready && bus.write_enable_1 && bus.write_release_1) busy_d[bus.write_address_1] = 1'b0;
        // reserve is applied last so it beats a release of the same register
        if (ready && bus.reserve_enable && !(HARDWIRED_ZERO && bus.reserve_address == '0))
            busy_d[bus.reserve_address] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= CLEAR;
            clear_index_q <= FIRST_INDEX;
            busy_q <= '0;
        end else begin
            state_q <= state_d;
            clear_index_q <= clear_index_d;
            busy_q <= busy_d;
        end
    end

    // storage has no reset of its own; the CLEAR walk zeroes it
    always_ff @(posedge clock) begin
        if (reset && state_q == CLEAR) storage_q[clear_index_q] <= '0;
        if (reset && write_0) storage_q[bus.write_address_0] <= bus.write_data_0;
        if (reset && write_1) storage_q[bus.write_address_1] <= bus.write_data_1;
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] address;
        assign address = bus.read_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        register_file_multiport_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDRESS_WIDTH(ADDRESS_WIDTH),
            .HARDWIRED_ZERO(HARDWIRED_ZERO)
        ) u_port (
            .ready_i(ready),
            .enable_i(bus.read_enable[p]),
            .address_i(address),
            .storage_word_i(storage_q[address]),
            .busy_i(busy_q[address]),
            .write_enable_0_i(bus.write_enable_0),
            .write_enable_1_i(bus.write_enable_1),
            .write_address_0_i(bus.write_address_0),
            .write_address_1_i(bus.write_address_1),
            .write_data_0_i(bus.write_data_0),
            .write_data_1_i(bus.write_data_1),
            .write_release_0_i(bus.write_release_0),
            .write_release_1_i(bus.write_release_1),
            .data_o(read_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o(read_busy[p])
        );
    end
endmodule

// File: tb/tb_register_file_multiport.sv
// tb_register_file_multiport: directed and randomized stimulus checked every cycle against
// a behavioural model of the register file, plus hand-computed literal expectations
module tb_register_file_multiport;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int DEPTH = 32;
    localparam bit HZ = 1'b1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    int m_cnt = 0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DEPTH-1:0] m_busy = '0;

    register_file_multiport_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_PORTS(RP)) bus ();

    register_file_multiport #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_PORTS(RP), .HARDWIRED_ZERO(HZ)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_cnt >= DEPTH - int'(HZ);
    endfunction

    function automatic logic [AW-1:0] raddr(int p);
        return bus.read_address[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] exp_data(int p);
        logic [AW-1:0] a;
        a = raddr(p);
        if (!m_ready() || !bus.read_enable[p] || (HZ && a == 0)) return '0;
        if (bus.write_enable_1 && bus.write_address_1 == a) return bus.write_data_1;
        if (bus.write_enable_0 && bus.write_address_0 == a) return bus.write_data_0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(int p);
        logic [AW-1:0] a;
        a = raddr(p);
        if (!m_ready() || !bus.read_enable[p]) return 1'b0;
        if (bus.write_enable_0 && bus.write_release_0 && bus.write_address_0 == a) return 1'b0;
        if (bus.write_enable_1 && bus.write_release_1 && bus.write_address_1 == a) return 1'b0;
        return m_busy[a];
    endfunction

    // model: after reset everything reads as zero once the clear walk has had DEPTH-HZ edges
    always @(posedge clock) begin
        if (!reset) begin
            m_cnt <= 0;
            m_busy <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else if (!m_ready()) begin
            m_cnt <= m_cnt + 1;
        end else begin
            if (bus.write_enable_0 && !(HZ && bus.write_address_0 == 0)) m_mem[bus.write_address_0] <= bus.write_data_0;
            if (bus.write_enable_1 && !(HZ && bus.write_address_1 == 0)) m_mem[bus.write_address_1] <= bus.write_data_1;
            if (bus.write_enable_0 && bus.write_release_0) m_busy[bus.write_address_0] <= 1'b0;
            if (bus.write_enable_1 && bus.write_release_1) m_busy[bus.write_address_1] <= 1'b0;
            if (bus.reserve_enable && !(HZ && bus.reserve_address == 0)) m_busy[bus.reserve_address] <= 1'b1;
        end
    end

    always @(negedge clock) begin
        check("ready", DW'(bus.ready), DW'(m_ready()));
        for (int p = 0; p < RP; p++) begin
            check($sformatf("read_data%0d", p), bus.read_data[p*DW +: DW], exp_data(p));
            check($sformatf("read_busy%0d", p), DW'(bus.read_busy[p]), DW'(exp_busy(p)));
        end
    end

    task automatic idle();
        bus.read_enable = '0;
        bus.read_address = '0;
        bus.write_enable_0 = 1'b0;
        bus.write_enable_1 = 1'b0;
        bus.write_address_0 = '0;
        bus.write_address_1 = '0;
        bus.write_data_0 = '0;
        bus.write_data_1 = '0;
        bus.write_release_0 = 1'b0;
        bus.write_release_1 = 1'b0;
        bus.reserve_enable = 1'b0;
        bus.reserve_address = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] rd(int p);
        return bus.read_data[p*DW +: DW];
    endfunction

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.read_enable = '1;
        bus.read_address = {a1, a0};
    endtask

    // walks the clear sequence with junk traffic that must be ignored
    task automatic wait_clear(input string tag);
        for (int k = 1; k <= DEPTH - int'(HZ); k++) begin
            read2(5'd9, 5'd5);
            bus.write_enable_0 = 1'b1;
            bus.write_address_0 = 5'd9;
            bus.write_data_0 = $urandom;
            bus.write_enable_1 = 1'b1;
            bus.write_address_1 = 5'd5;
            bus.write_data_1 = 32'h0000_1234;
            bus.reserve_enable = 1'b1;
            bus.reserve_address = 5'd9;
            tick();
            if (k == 15) begin
                check({tag, " clear rdata0"}, rd(0), 32'h0);
                check({tag, " clear rbusy0"}, DW'(bus.read_busy[0]), 32'h0);
            end
            if (k == DEPTH - 2) check({tag, " ready edge30"}, DW'(bus.ready), 32'h0);
            if (k == DEPTH - 1) check({tag, " ready edge31"}, DW'(bus.ready), 32'h1);
        end
        idle();
        read2(5'd9, 5'd5);
        #1;
        check({tag, " r9 zeroed"}, rd(0), 32'h0);
        check({tag, " r5 zeroed"}, rd(1), 32'h0);
        check({tag, " r9 not busy"}, DW'(bus.read_busy[0]), 32'h0);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_clear("boot");

        tick(); idle();
        bus.write_enable_0 = 1'b1; bus.write_address_0 = 5'd5; bus.write_data_0 = 32'hDEAD_BEEF;
        read2(5'd5, 5'd1);
        #1 check("bypass r5", rd(0), 32'hDEAD_BEEF);
        tick(); idle(); read2(5'd5, 5'd1);
        #1 check("stored r5", rd(0), 32'hDEAD_BEEF);

        tick(); idle();
        bus.write_enable_0 = 1'b1; bus.write_address_0 = 5'd7; bus.write_data_0 = 32'h11;
        bus.write_enable_1 = 1'b1; bus.write_address_1 = 5'd7; bus.write_data_1 = 32'h22;
        read2(5'd2, 5'd7);
        #1 check("bypass r7 p1 wins", rd(1), 32'h22);
        tick(); idle(); read2(5'd2, 5'd7);
        #1 check("stored r7 p1 wins", rd(1), 32'h22);

        tick(); idle();
        bus.write_enable_0 = 1'b1; bus.write_address_0 = 5'd0; bus.write_data_0 = 32'hFFFF_FFFF;
        bus.reserve_enable = 1'b1; bus.reserve_address = 5'd0;
        read2(5'd0, 5'd0);
        #1 check("r0 bypass blocked", rd(0), 32'h0);
        tick(); idle(); read2(5'd0, 5'd0);
        #1 check("r0 reads zero", rd(0), 32'h0);
        check("r0 never busy", DW'(bus.read_busy[0]), 32'h0);

        tick(); idle();
        bus.reserve_enable = 1'b1; bus.reserve_address = 5'd3;
        read2(5'd3, 5'd3);
        #1 check("reserve not visible yet", DW'(bus.read_busy[0]), 32'h0);
        tick(); idle(); read2(5'd3, 5'd3);
        #1 check("r3 busy", DW'(bus.read_busy[0]), 32'h1);
        bus.write_enable_0 = 1'b1; bus.write_address_0 = 5'd3; bus.write_data_0 = 32'hAB;
        bus.write_release_0 = 1'b1;
        #1 check("release masks busy", DW'(bus.read_busy[1]), 32'h0);
        tick(); idle(); read2(5'd3, 5'd3);
        #1 check("r3 released", DW'(bus.read_busy[0]), 32'h0);
        check("r3 data", rd(0), 32'hAB);
        bus.reserve_enable = 1'b1; bus.reserve_address = 5'd3;
        tick(); idle(); read2(5'd3, 5'd3);
        bus.reserve_enable = 1'b1; bus.reserve_address = 5'd3;
        bus.write_enable_1 = 1'b1; bus.write_address_1 = 5'd3; bus.write_data_1 = 32'hCD;
        bus.write_release_1 = 1'b1;
        tick(); idle(); read2(5'd3, 5'd3);
        #1 check("reserve beats release", DW'(bus.read_busy[0]), 32'h1);
        check("r3 data cd", rd(0), 32'hCD);

        for (int i = 0; i < 600; i++) begin
            tick();
            bus.read_enable = RP'($urandom);
            bus.read_address = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus.write_enable_0 = 1'($urandom);
            bus.write_enable_1 = 1'($urandom);
            bus.write_address_0 = AW'($urandom_range(0, 7));
            bus.write_address_1 = AW'($urandom_range(0, 7));
            bus.write_data_0 = $urandom;
            bus.write_data_1 = $urandom;
            bus.write_release_0 = 1'($urandom);
            bus.write_release_1 = 1'($urandom);
            bus.reserve_enable = 1'($urandom);
            bus.reserve_address = AW'($urandom_range(0, 7));
        end

        tick(); idle();
        bus.reserve_enable = 1'b1; bus.reserve_address = 5'd4;
        tick(); idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            bus.write_enable_0 = 1'b1; bus.write_address_0 = 5'd5; bus.write_data_0 = 32'h1234;
            tick();
        end
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        read2(5'd4, 5'd4);
        #1 check("mid-clear reset busy r4", DW'(bus.read_busy[0]), 32'h0);
        wait_clear("restart");
        read2(5'd4, 5'd5);
        #1 check("r4 busy cleared", DW'(bus.read_busy[0]), 32'h0);
        check("r5 write in clear lost", rd(1), 32'h0);

        tick(); idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
